// File: rtl/dram_chip_seq_if.sv
// Command/DQ bundle between the rank-level command decoder (master) and the
// per-chip burst sequencer (slave).
interface dram_chip_seq_if #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 4,
  parameter int COLWIDTH     = 5,
  parameter int DEVICE_WIDTH = 4
);
  localparam int NBANKS = 2 ** (BGWIDTH + BAWIDTH);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd;
  logic [BGWIDTH-1:0]      cmd_bg;
  logic [BAWIDTH-1:0]      cmd_ba;
  logic [ADDRWIDTH-1:0]    cmd_row;
  logic [COLWIDTH-1:0]     cmd_col;
  logic                    cmd_bc4;
  logic [DEVICE_WIDTH-1:0] dq_in;
  logic [DEVICE_WIDTH-1:0] dq_out;
  logic                    dq_rvalid;
  logic                    dq_wstrobe;
  logic                    cmd_err;
  logic [NBANKS-1:0]       bank_open;

  modport master (
    output cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_bc4, dq_in,
    input  cmd_ready, dq_out, dq_rvalid, dq_wstrobe, cmd_err, bank_open
  );

  modport slave (
    input  cmd_valid, cmd, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_bc4, dq_in,
    output cmd_ready, dq_out, dq_rvalid, dq_wstrobe, cmd_err, bank_open
  );
endinterface

// File: rtl/dram_chip_seq.sv
// DDR-style chip model: per-bank open-row tracking, ACT/RD/WR/PRE/PREA decode,
// and BL8/BC4 burst sequencing with fixed CL/CWL over one shared DQ bus.
module dram_chip_seq #(
  parameter int BGWIDTH      = 2,
  parameter int BAWIDTH      = 2,
  parameter int ADDRWIDTH    = 4,
  parameter int COLWIDTH     = 5,
  parameter int DEVICE_WIDTH = 4,
  parameter int BL           = 8,
  parameter int CL           = 3,
  parameter int CWL          = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dram_chip_seq_if.slave  bus
);
  localparam int BANKGROUPS    = 2 ** BGWIDTH;
  localparam int BANKSPERGROUP = 2 ** BAWIDTH;
  localparam int NBANKS        = BANKGROUPS * BANKSPERGROUP;
  localparam int BKW           = BGWIDTH + BAWIDTH;
  localparam int MEMW          = BKW + ADDRWIDTH + COLWIDTH;
  localparam int MEMD          = 2 ** MEMW;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_BURST} state_t;
  typedef enum logic [2:0] {C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2, C_WR = 3'd3,
                            C_PRE = 3'd4, C_PREA = 3'd5} cmd_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [2:0]              beat_q, beat_d;
  logic [BKW-1:0]          bank_q, bank_d;
  logic [ADDRWIDTH-1:0]    row_q, row_d;
  logic [COLWIDTH-1:0]     col_q, col_d;
  logic                    bc4_q, bc4_d;
  logic [NBANKS-1:0]       open_q, open_d;
  logic [ADDRWIDTH-1:0]    open_row_q [NBANKS];
  logic                    act_we;
  logic                    err_q, err_d;
  logic [DEVICE_WIDTH-1:0] dq_out_q, dq_out_d;
  logic [DEVICE_WIDTH-1:0] mem [MEMD];
  logic [BKW-1:0]          bank_sel;
  logic                    last_beat;
  logic [MEMW-1:0]         rd_addr, wr_addr;

  // Sequential wrap inside the aligned 8-column (BL8) or 4-column (BC4) block.
  function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] c,
                                                   input logic [2:0] k,
                                                   input logic chop);
    logic [COLWIDTH-1:0] r;
    r = c;
    if (chop) r[1:0] = c[1:0] + k[1:0];
    else      r[2:0] = c[2:0] + k;
    return r;
  endfunction

  assign bank_sel  = {bus.cmd_bg, bus.cmd_ba};
  assign last_beat = bc4_q ? (beat_q == 3'(BL / 2 - 1)) : (beat_q == 3'(BL - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    bc4_d   = bc4_q;
    open_d  = open_q;
    act_we  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            C_NOP: ;
            C_ACT: begin
              if (open_q[bank_sel]) err_d = 1'b1;
              else begin
                open_d[bank_sel] = 1'b1;
                act_we           = 1'b1;
              end
            end
            C_RD, C_WR: begin
              if (!open_q[bank_sel]) err_d = 1'b1;
              else begin
                bank_d = bank_sel;
                row_d  = open_row_q[bank_sel];
                col_d  = bus.cmd_col;
                bc4_d  = bus.cmd_bc4;
                beat_d = '0;
                if (bus.cmd == C_RD) begin
                  cnt_d   = 4'(CL - 1);
                  state_d = (CL == 1) ? RD_BURST : RD_WAIT;
                end else begin
                  cnt_d   = 4'(CWL - 1);
                  state_d = (CWL == 1) ? WR_BURST : WR_WAIT;
                end
              end
            end
            C_PRE:  open_d[bank_sel] = 1'b0;
            C_PREA: open_d = '0;
            default: err_d = 1'b1;
          endcase
        end
      end
      // Counter holds the remaining wait cycles; the last one hands over to the burst.
      RD_WAIT: begin
        if (cnt_q == 4'd1) state_d = RD_BURST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WR_WAIT: begin
        if (cnt_q == 4'd1) state_d = WR_BURST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RD_BURST: begin
        if (last_beat) state_d = IDLE;
        else           beat_d  = beat_q + 3'd1;
      end
      WR_BURST: begin
        if (last_beat) state_d = IDLE;
        else           beat_d  = beat_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is looked up for the beat the next cycle will present, so dq_out is a flop.
  assign rd_addr  = {bank_d, row_d, beat_col(col_d, beat_d, bc4_d)};
  assign wr_addr  = {bank_q, row_q, beat_col(col_q, beat_q, bc4_q)};
  assign dq_out_d = (state_d == RD_BURST) ? mem[rd_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      bc4_q    <= 1'b0;
      open_q   <= '0;
      err_q    <= 1'b0;
      dq_out_q <= '0;
      for (int unsigned i = 0; i < NBANKS; i++) open_row_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      col_q    <= col_d;
      bc4_q    <= bc4_d;
      open_q   <= open_d;
      err_q    <= err_d;
      dq_out_q <= dq_out_d;
      if (act_we) open_row_q[bank_sel] <= bus.cmd_row;
    end
  end

  // Storage is not reset; a reset mid-burst forces IDLE asynchronously, which blocks writes.
  always_ff @(posedge clk) begin
    if (state_q == WR_BURST) mem[wr_addr] <= bus.dq_in;
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.dq_rvalid  = (state_q == RD_BURST);
  assign bus.dq_wstrobe = (state_q == WR_BURST);
  assign bus.dq_out     = dq_out_q;
  assign bus.cmd_err    = err_q;
  assign bus.bank_open  = open_q;
endmodule

// File: tb/tb_dram_chip_seq.sv
// Bench for dram_chip_seq: command table, hand-written burst/reset sequences and
// random traffic checked against a transaction-level bank/memory model.
module tb_dram_chip_seq;
  localparam int BGW = 2, BAW = 2, AW = 4, CW = 5, DW = 4;
  localparam int TCL = 3, TCWL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_chip_seq_if #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
                     .DEVICE_WIDTH(DW)) bus ();

  dram_chip_seq #(.BGWIDTH(BGW), .BAWIDTH(BAW), .ADDRWIDTH(AW), .COLWIDTH(CW),
                  .DEVICE_WIDTH(DW), .BL(8), .CL(TCL), .CWL(TCWL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int passed = 0;

  // Reference model: bank open flags, open rows, storage with known-flags.
  bit         mopen [16];
  logic [3:0] mrow  [16];
  logic [3:0] mmem  [8192];
  bit         mknown[8192];

  typedef struct {
    int         c, bg, ba, row;
    bit         exp_err;
    logic [15:0] exp_open;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
    else passed++;
  endtask

  function automatic logic [15:0] mopenv();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = mopen[i];
    return v;
  endfunction

  function automatic int colk(input int col, input int k, input bit bc4);
    if (bc4) return (col & ~3) | ((col + k) % 4);
    return (col & ~7) | ((col + k) % 8);
  endfunction

  function automatic int maddr(input int bank, input int row, input int col);
    return (bank * 16 + row) * 32 + col;
  endfunction

  // Issues one command (called at a negedge) and follows any burst it starts.
  // Returns at the negedge of the last busy cycle (or right after the accept cycle).
  task automatic run(input int c, input int bg, input int ba, input int row, input int col,
                     input bit bc4, input logic [31:0] wd, input int abort,
                     output logic [31:0] rb, output logic oerr, output logic [15:0] oopen);
    int  bank, lat, n, k, a, r, t;
    bit  exp_err, burst;
    rb = '0;
    bank = bg * 4 + ba;
    exp_err = (c == 1 && mopen[bank]) || ((c == 2 || c == 3) && !mopen[bank]) || c >= 6;
    burst = (c == 2 || c == 3) && !exp_err;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("ready_timeout", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'(c);
    bus.cmd_bg    = 2'(bg);
    bus.cmd_ba    = 2'(ba);
    bus.cmd_row   = 4'(row);
    bus.cmd_col   = 5'(col);
    bus.cmd_bc4   = bc4;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    oerr  = bus.cmd_err;
    oopen = bus.bank_open;
    if (!exp_err) begin
      if (c == 1) begin mopen[bank] = 1'b1; mrow[bank] = 4'(row); end
      if (c == 4) mopen[bank] = 1'b0;
      if (c == 5) for (int i = 0; i < 16; i++) mopen[i] = 1'b0;
    end
    chk("cmd_err", 32'(oerr), 32'(exp_err));
    chk("bank_open", 32'(oopen), 32'(mopenv()));
    if (burst) begin
      lat = (c == 2) ? TCL : TCWL;
      n   = bc4 ? 4 : 8;
      r   = int'(mrow[bank]);
      for (int j = 1; j <= lat + n; j++) begin
        if (j > 1) @(negedge clk);
        k = j - lat;
        if (c == 3 && abort >= 0 && k == abort) begin
          rst_n = 1'b0;
          #1;
          chk("abort_wstrobe", 32'(bus.dq_wstrobe), 32'd0);
          chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
          chk("abort_bank_open", 32'(bus.bank_open), 32'd0);
          chk("abort_rvalid", 32'(bus.dq_rvalid), 32'd0);
          for (int i = 0; i < 16; i++) mopen[i] = 1'b0;
          repeat (2) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (c == 2) begin
          chk("rvalid", 32'(bus.dq_rvalid), 32'(k >= 0 && k < n));
          if (k >= 0 && k < n) begin
            a = maddr(bank, r, colk(col, k, bc4));
            rb[4*k +: 4] = bus.dq_out;
            if (mknown[a]) chk("rd_data", 32'(bus.dq_out), 32'(mmem[a]));
          end else chk("dq_out_idle", 32'(bus.dq_out), 32'd0);
        end else begin
          chk("wstrobe", 32'(bus.dq_wstrobe), 32'(k >= 0 && k < n));
          if (k >= 0 && k < n) begin
            a = maddr(bank, r, colk(col, k, bc4));
            bus.dq_in = wd[4*k +: 4];
            mmem[a]   = wd[4*k +: 4];
            mknown[a] = 1'b1;
          end
        end
        chk("busy_ready", 32'(bus.cmd_ready), 32'(j == lat + n));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rb;
    logic        oerr;
    logic [15:0] oopen;
    int c, sel;

    tbl[0]  = '{2, 0, 0, 0, 1'b1, 16'h0000};
    tbl[1]  = '{1, 0, 1, 3, 1'b0, 16'h0002};
    tbl[2]  = '{1, 0, 1, 4, 1'b1, 16'h0002};
    tbl[3]  = '{0, 2, 2, 0, 1'b0, 16'h0002};
    tbl[4]  = '{6, 0, 0, 0, 1'b1, 16'h0002};
    tbl[5]  = '{7, 1, 1, 0, 1'b1, 16'h0002};
    tbl[6]  = '{4, 0, 2, 0, 1'b0, 16'h0002};
    tbl[7]  = '{1, 1, 2, 5, 1'b0, 16'h0042};
    tbl[8]  = '{1, 3, 3, 1, 1'b0, 16'h8042};
    tbl[9]  = '{5, 0, 0, 0, 1'b0, 16'h0000};
    tbl[10] = '{3, 1, 2, 0, 1'b1, 16'h0000};
    tbl[11] = '{2, 3, 3, 0, 1'b1, 16'h0000};
    tbl[12] = '{1, 1, 2, 5, 1'b0, 16'h0040};
    tbl[13] = '{4, 1, 2, 0, 1'b0, 16'h0000};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.cmd_bg = '0; bus.cmd_ba = '0;
    bus.cmd_row = '0; bus.cmd_col = '0; bus.cmd_bc4 = 1'b0; bus.dq_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_bank_open", 32'(bus.bank_open), 32'd0);
    chk("rst_rvalid", 32'(bus.dq_rvalid), 32'd0);
    chk("rst_wstrobe", 32'(bus.dq_wstrobe), 32'd0);
    chk("rst_err", 32'(bus.cmd_err), 32'd0);
    chk("rst_dq_out", 32'(bus.dq_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run(tbl[i].c, tbl[i].bg, tbl[i].ba, tbl[i].row, 0, 1'b0, '0, -1, rb, oerr, oopen);
      chk("tbl_err", 32'(oerr), 32'(tbl[i].exp_err));
      chk("tbl_open", 32'(oopen), 32'(tbl[i].exp_open));
      chk("tbl_no_rvalid", 32'(bus.dq_rvalid), 32'd0);
    end

    // BL8 write at col 0x0A wraps inside 0x08..0x0F; then BL8 and BC4 reads.
    run(1, 1, 2, 5, 0, 1'b0, '0, -1, rb, oerr, oopen);
    run(3, 1, 2, 0, 5'h0A, 1'b0, 32'h76543210, -1, rb, oerr, oopen);
    run(2, 1, 2, 0, 5'h08, 1'b0, '0, -1, rb, oerr, oopen);
    chk("rd_bl8_wrap", rb, 32'h54321076);
    run(2, 1, 2, 0, 5'h0B, 1'b1, '0, -1, rb, oerr, oopen);
    chk("rd_bc4_wrap", {16'h0, rb[15:0]}, 32'h00000761);

    // Reset at beat 3 of a write: beats 0..2 land, the rest keep old data.
    run(3, 1, 2, 0, 5'h08, 1'b0, 32'hFEDCBA98, 3, rb, oerr, oopen);
    @(negedge clk);
    run(1, 1, 2, 5, 0, 1'b0, '0, -1, rb, oerr, oopen);
    run(2, 1, 2, 0, 5'h08, 1'b0, '0, -1, rb, oerr, oopen);
    chk("rd_after_abort", rb, 32'h54321A98);

    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 99);
      if      (sel < 20) c = 1;
      else if (sel < 45) c = 3;
      else if (sel < 75) c = 2;
      else if (sel < 85) c = 4;
      else if (sel < 88) c = 5;
      else if (sel < 94) c = 0;
      else               c = $urandom_range(6, 7);
      run(c, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
          $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom, -1, rb, oerr, oopen);
    end

    @(negedge clk);
    chk("end_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("end_err_clear", 32'(bus.cmd_err), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
